nic_vc_rx_buffer: RTL

- Parametrised receive buffer for the network interface. It replaces the single-queue rx buffer with NUM_VC independent per-virtual-channel FIFOs.
- Flits arrive from the router port tagged with a VC id and are stored in that VC's FIFO.
- A round-robin arbiter presents one head flit at a time to the host over a valid/ready handshake.
- Per-VC occupancy state (EMPTY/VACANT/FULL/OVERFULL) and sticky overflow flags are exported to the host signal path.

---
 rtl/nic_pkg.sv | 17 +
 rtl/nic_vc_fifo.sv | 59 +++++
 rtl/nic_vc_rx_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// Shared types and helpers for the NIC per-VC receive buffer.
package nic_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    VACANT   = 2'd1,
    FULL     = 2'd2,
    OVERFULL = 2'd3
  } buffer_state_t;

  localparam int unsigned DEF_FLIT_WIDTH = 32;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_vc);
    return (ptr + 32'd1 >= num_vc) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/nic_vc_fifo.sv
// Single-VC first-word fall-through FIFO with wrap-bit pointers and sticky overflow flag.
module nic_vc_fifo
  import nic_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push_req,
  input  logic [FLIT_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  input  logic                  i_ovf_clear,
  output logic [FLIT_WIDTH-1:0] o_head,
  output logic [CW-1:0]         o_count_next,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_ovf,
  output logic                  o_ovf_next
);

  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic                  r_ovf;
  logic [CW-1:0]         w_count;
  logic                  w_push;
  logic                  w_drop;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign o_full       = (w_count == CW'(DEPTH));
  assign o_empty      = (w_count == '0);
  // Acceptance looks only at the current count, so a same-cycle pop never frees a slot.
  assign w_push       = i_push_req && !o_full;
  assign w_drop       = i_push_req && o_full;
  assign o_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count_next = w_count + CW'(w_push) - CW'(i_pop);
  assign o_ovf_next   = w_drop | (r_ovf & ~i_ovf_clear);
  assign o_ovf        = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
      r_ovf <= o_ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/nic_vc_rx_buffer.sv
// NIC receive buffer: NUM_VC per-VC FIFOs behind a round-robin host arbiter.
// Define NIC_CREDIT_RETURN_EN to add credit_ret / credit_cnt outputs.
module nic_vc_rx_buffer
  import nic_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_VC     = 4,
  localparam int unsigned VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic [VC_W-1:0]       in_vc,
  input  logic                  in_valid,
  output logic [NUM_VC-1:0]     in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [VC_W-1:0]       out_vc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NUM_VC-1:0]   vc_state,
  output logic [NUM_VC-1:0]     ovf_flag,
  input  logic [NUM_VC-1:0]     ovf_clear
`ifdef NIC_CREDIT_RETURN_EN
  ,
  output logic [NUM_VC-1:0]     credit_ret,
  output logic [NUM_VC*CW-1:0]  credit_cnt
`endif
);

  logic [FLIT_WIDTH-1:0] w_head       [NUM_VC];
  logic [CW-1:0]         w_count_next [NUM_VC];
  logic [NUM_VC-1:0]     w_full;
  logic [NUM_VC-1:0]     w_empty;
  logic [NUM_VC-1:0]     w_ovf;
  logic [NUM_VC-1:0]     w_ovf_next;
  logic [NUM_VC-1:0]     w_push_req;
  logic [NUM_VC-1:0]     w_pop;
  logic [VC_W-1:0]       w_scan_idx;
  logic [VC_W-1:0]       w_sel_vc;
  logic [VC_W-1:0]       w_grant_vc;
  logic                  w_any;
  logic                  w_fire;
  logic [2*NUM_VC-1:0]   w_vc_state_d;
  logic [VC_W-1:0]       r_rr_ptr;
  logic [VC_W-1:0]       r_hold_vc;
  logic                  r_hold;
  logic [2*NUM_VC-1:0]   r_vc_state;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    // Out-of-range VC ids match no lane and are silently ignored.
    assign w_push_req[g] = in_valid && (in_vc == VC_W'(g));
    assign w_pop[g]      = w_fire && (w_grant_vc == VC_W'(g));

    nic_vc_fifo #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_req   (w_push_req[g]),
      .i_data       (in_flit),
      .i_pop        (w_pop[g]),
      .i_ovf_clear  (ovf_clear[g]),
      .o_head       (w_head[g]),
      .o_count_next (w_count_next[g]),
      .o_full       (w_full[g]),
      .o_empty      (w_empty[g]),
      .o_ovf        (w_ovf[g]),
      .o_ovf_next   (w_ovf_next[g])
    );
  end

  always_comb begin
    w_sel_vc   = '0;
    w_any      = 1'b0;
    w_scan_idx = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      w_scan_idx = VC_W'((32'(r_rr_ptr) + i) % NUM_VC);
      if (!w_any && !w_empty[w_scan_idx]) begin
        w_any    = 1'b1;
        w_sel_vc = w_scan_idx;
      end
    end
  end

  // A stalled offer keeps its grant so out_vc/out_flit stay stable until accepted.
  assign w_grant_vc = r_hold ? r_hold_vc : w_sel_vc;
  assign out_valid  = r_hold | w_any;
  assign w_fire     = out_valid && out_ready;
  assign out_vc     = out_valid ? w_grant_vc : '0;
  assign out_flit   = out_valid ? w_head[w_grant_vc] : '0;
  assign in_ready   = ~w_full;
  assign ovf_flag   = w_ovf;
  assign vc_state   = r_vc_state;

  always_comb begin
    w_vc_state_d = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_ovf_next[v])                        w_vc_state_d[2*v +: 2] = OVERFULL;
      else if (w_count_next[v] == '0)           w_vc_state_d[2*v +: 2] = EMPTY;
      else if (w_count_next[v] == CW'(DEPTH))   w_vc_state_d[2*v +: 2] = FULL;
      else                                      w_vc_state_d[2*v +: 2] = VACANT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_hold     <= 1'b0;
      r_hold_vc  <= '0;
      r_vc_state <= '0;
    end else begin
      r_hold     <= out_valid && !out_ready;
      r_hold_vc  <= w_grant_vc;
      r_vc_state <= w_vc_state_d;
      if (w_fire) r_rr_ptr <= VC_W'(rr_next(32'(w_grant_vc), NUM_VC));
    end
  end

`ifdef NIC_CREDIT_RETURN_EN
  logic [NUM_VC-1:0]    r_credit_ret;
  logic [NUM_VC*CW-1:0] r_credit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_ret <= '0;
      r_credit_cnt <= {NUM_VC{CW'(DEPTH)}};
    end else begin
      r_credit_ret <= w_pop;
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit_cnt[v*CW +: CW] <= CW'(DEPTH) - w_count_next[v];
      end
    end
  end

  assign credit_ret = r_credit_ret;
  assign credit_cnt = r_credit_cnt;
`endif

endmodule
